// File: rtl/i2c_pkg.sv
// Shared definitions for the i2c transaction sequencer and its engine command issuer.
package i2c_pkg;

  // Instruction encodings understood by the i2c byte engine
  typedef enum logic [1:0] {
    INSTR_START = 2'd0,
    INSTR_STOP  = 2'd1,
    INSTR_READ  = 2'd2,
    INSTR_WRITE = 2'd3
  } eng_instr_t;

  // Transaction-level sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_FETCH,
    S_WRITE,
    S_READ,
    S_STOP,
    S_DONE
  } seq_state_t;

  // Per-command engine handshake states
  typedef enum logic [1:0] {
    C_IDLE,
    C_BLANK,
    C_WAIT,
    C_RELEASE
  } cmd_state_t;

  // Engine holds eng_enable low this long between commands by default
  localparam int GUARD_CYCLES_DEF = 2;
  // A stale eng_complete from the previous command survives this many clk
  localparam int BLANK_CYCLES = 2;

endpackage

// File: rtl/i2c_cmd_issuer.sv
// Runs one engine command: ISSUE, BLANK (ignore stale complete), WAIT for
// complete, RELEASE (enable low for GUARD_CYCLES), then pulses cmd_done.
module i2c_cmd_issuer
  import i2c_pkg::*;
#(
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_instr,
  input  logic [7:0] cmd_byte,
  output logic       cmd_done,
  output logic [1:0] eng_instruction,
  output logic       eng_enable,
  output logic [7:0] eng_byte_to_send,
  input  logic       eng_complete
);

  localparam int CNT_W = $clog2(GUARD_CYCLES + BLANK_CYCLES);

  cmd_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_done;
  logic             r_enable;
  logic [1:0]       r_instr;
  logic [7:0]       r_byte;

  assign cmd_ready        = r_ready;
  assign cmd_done         = r_done;
  assign eng_enable       = r_enable;
  assign eng_instruction  = r_instr;
  assign eng_byte_to_send = r_byte;

  // Command handshake FSM; instruction/byte only change when accepting in C_IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= C_IDLE;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_enable <= 1'b0;
      r_instr  <= '0;
      r_byte   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        C_IDLE: begin
          if (cmd_valid) begin
            r_instr  <= cmd_instr;
            r_byte   <= cmd_byte;
            r_enable <= 1'b1;
            r_ready  <= 1'b0;
            r_cnt    <= '0;
            r_state  <= C_BLANK;
          end
        end
        C_BLANK: begin
          if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= C_WAIT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        C_WAIT: begin
          if (eng_complete) begin
            r_enable <= 1'b0;
            r_cnt    <= '0;
            r_state  <= C_RELEASE;
          end
        end
        C_RELEASE: begin
          if (r_cnt == CNT_W'(GUARD_CYCLES - 1)) begin
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= C_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Transaction controller for the i2c byte engine: START, address byte,
// N data bytes (write stream or read stream), STOP.
// Optional macro I2C_TXN_SEQUENCER_AUTOREPEAT_EN re-launches the last
// accepted request every REPEAT_CYCLES clk while idle.
module i2c_txn_sequencer
  import i2c_pkg::*;
#(
  parameter int LEN_W         = 4,
  parameter int GUARD_CYCLES  = GUARD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = 540000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic             req_rnw,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             done,
  output logic [1:0]       eng_instruction,
  output logic             eng_enable,
  output logic [7:0]       eng_byte_to_send,
  input  logic [7:0]       eng_byte_received,
  input  logic             eng_complete
);

  if (GUARD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("i2c_txn_sequencer: GUARD_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  seq_state_t       r_state;
  logic [6:0]       r_addr;
  logic             r_rnw;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_wr_ready;
  logic             r_rd_valid;
  logic [7:0]       r_rd_data;
  logic [7:0]       r_wbyte;
  logic             r_cmd_valid;
  logic [1:0]       r_cmd_instr;
  logic [7:0]       r_cmd_byte;
  logic             r_issued;

  logic             w_cmd_ready;
  logic             w_cmd_done;
  logic             w_is_cmd;
  eng_instr_t       w_instr;
  logic [7:0]       w_byte;
  logic             w_accept;
  logic             w_rpt_launch;

  assign w_accept  = req_valid && r_req_ready;
  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign wr_ready  = r_wr_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

`ifdef I2C_TXN_SEQUENCER_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);

  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_have_req;
  logic             w_rpt_fire;

  assign w_rpt_fire   = (r_rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));
  assign w_rpt_launch = w_rpt_fire && (r_state == S_IDLE) && r_have_req && !req_valid;

  // Free-running repeat period; an external request restarts the period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_cnt  <= '0;
      r_have_req <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rpt_cnt  <= '0;
        r_have_req <= 1'b1;
      end else if (w_rpt_fire) begin
        r_rpt_cnt <= '0;
      end else begin
        r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
      end
    end
  end
`else
  assign w_rpt_launch = 1'b0;
`endif

  // Engine command implied by the current sequencer state
  always_comb begin
    w_is_cmd = 1'b0;
    w_instr  = INSTR_START;
    w_byte   = '0;
    case (r_state)
      S_START: w_is_cmd = 1'b1;
      S_ADDR: begin
        w_is_cmd = 1'b1;
        w_instr  = INSTR_WRITE;
        w_byte   = {r_addr, r_rnw};
      end
      S_WRITE: begin
        w_is_cmd = 1'b1;
        w_instr  = INSTR_WRITE;
        w_byte   = r_wbyte;
      end
      S_READ: begin
        w_is_cmd = 1'b1;
        w_instr  = INSTR_READ;
      end
      S_STOP: begin
        w_is_cmd = 1'b1;
        w_instr  = INSTR_STOP;
      end
      default: ;
    endcase
  end

  // Transaction sequencer; each command state hands one command to the
  // issuer (shared handshake above the case) and advances on cmd_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rnw       <= 1'b0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_ready  <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_wbyte     <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_instr <= '0;
      r_cmd_byte  <= '0;
      r_issued    <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_wr_ready <= 1'b0;
      r_rd_valid <= 1'b0;

      if (w_is_cmd && !r_issued) begin
        if (r_cmd_valid && w_cmd_ready) begin
          r_cmd_valid <= 1'b0;
          r_issued    <= 1'b1;
        end else begin
          r_cmd_valid <= 1'b1;
          r_cmd_instr <= w_instr;
          r_cmd_byte  <= w_byte;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr      <= req_addr;
            r_rnw       <= req_rnw;
            r_len       <= req_len;
            r_cnt       <= req_len;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end else if (w_rpt_launch) begin
            r_cnt       <= r_len;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          if (r_issued && w_cmd_done) begin
            r_issued <= 1'b0;
            r_state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (r_issued && w_cmd_done) begin
            r_issued <= 1'b0;
            if (r_cnt == '0)  r_state <= S_STOP;
            else if (r_rnw)   r_state <= S_READ;
            else              r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (wr_valid) begin
            r_wr_ready <= 1'b1;
            r_wbyte    <= wr_data;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_issued && w_cmd_done) begin
            r_issued <= 1'b0;
            r_cnt    <= r_cnt - LEN_W'(1);
            r_state  <= (r_cnt == LEN_W'(1)) ? S_STOP : S_FETCH;
          end
        end
        S_READ: begin
          if (r_issued && w_cmd_done) begin
            r_issued   <= 1'b0;
            r_rd_data  <= eng_byte_received;
            r_rd_valid <= 1'b1;
            r_cnt      <= r_cnt - LEN_W'(1);
            r_state    <= (r_cnt == LEN_W'(1)) ? S_STOP : S_READ;
          end
        end
        S_STOP: begin
          if (r_issued && w_cmd_done) begin
            r_issued <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  i2c_cmd_issuer #(
    .GUARD_CYCLES(GUARD_CYCLES)
  ) u_cmd_issuer (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (r_cmd_valid),
    .cmd_ready        (w_cmd_ready),
    .cmd_instr        (r_cmd_instr),
    .cmd_byte         (r_cmd_byte),
    .cmd_done         (w_cmd_done),
    .eng_instruction  (eng_instruction),
    .eng_enable       (eng_enable),
    .eng_byte_to_send (eng_byte_to_send),
    .eng_complete     (eng_complete)
  );

endmodule
